// File: rtl/simple_fixed_point_signed_multiplier_if.sv
// Request/response bundle for the sequential fixed-point signed multiplier.
// The master side drives operands and start; the slave side returns the product.
interface simple_fixed_point_signed_multiplier_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] data_in_a;
  logic [WIDTH-1:0] data_in_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_out;
  logic             overflow;

  modport master (
    output start, data_in_a, data_in_b,
    input  busy, done, data_out, overflow
  );

  modport slave (
    input  start, data_in_a, data_in_b,
    output busy, done, data_out, overflow
  );
endinterface

// File: rtl/simple_fixed_point_signed_multiplier.sv
// Sequential signed Q-format multiplier: shift-add on operand magnitudes, then
// rescale by FRAC, restore the sign and saturate to the WIDTH-bit range.
module simple_fixed_point_signed_multiplier #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4
) (
  input logic                           clk,
  input logic                           reset_n,
  simple_fixed_point_signed_multiplier_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST_ITER   = CW'(WIDTH - 1);
  localparam logic [PW-1:0]    POS_LIMIT   = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic [PW-1:0]    NEG_LIMIT   = {{WIDTH{1'b0}}, 1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [WIDTH-1:0] OUT_POS_MAX = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic [WIDTH-1:0] OUT_NEG_MAX = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    iter;
  logic             sign;

  logic             done_q;
  logic [WIDTH-1:0] data_out_q;
  logic             overflow_q;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [PW-1:0]    scaled;
  logic [WIDTH-1:0] result;
  logic             result_ovf;

  // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude.
  assign mag_a = bus.data_in_a[WIDTH-1] ? -bus.data_in_a : bus.data_in_a;
  assign mag_b = bus.data_in_b[WIDTH-1] ? -bus.data_in_b : bus.data_in_b;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (iter == LAST_ITER) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state != IDLE);
    bus.done     = done_q;
    bus.data_out = data_out_q;
    bus.overflow = overflow_q;
  end

  // Shift-add datapath; operands are frozen in these registers at acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      iter   <= '0;
      sign   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            sign   <= bus.data_in_a[WIDTH-1] ^ bus.data_in_b[WIDTH-1];
            acc    <= '0;
            iter   <= '0;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          iter   <= iter + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Truncating the magnitude rounds toward zero for both signs.
  always_comb begin
    scaled     = acc >> FRAC;
    result     = scaled[WIDTH-1:0];
    result_ovf = 1'b0;
    if (!sign) begin
      if (scaled > POS_LIMIT) begin
        result     = OUT_POS_MAX;
        result_ovf = 1'b1;
      end
    end else begin
      if (scaled > NEG_LIMIT) begin
        result     = OUT_NEG_MAX;
        result_ovf = 1'b1;
      end else begin
        result = -scaled[WIDTH-1:0];
      end
    end
  end

  // Results are held between done pulses; done itself lasts one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q     <= 1'b0;
      data_out_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= (state == FINISH);
      if (state == FINISH) begin
        data_out_q <= result;
        overflow_q <= result_ovf;
      end
    end
  end

  busy_done_exclusive: assert property (
    @(posedge clk) disable iff (!reset_n) !(bus.busy && bus.done)
  );

endmodule

// File: tb/tb_simple_fixed_point_signed_multiplier.sv
// Self-checking bench: directed Q4.4 vectors, handshake and reset scenarios, and
// randomized operands checked against a plain-integer arithmetic model.
module tb_simple_fixed_point_signed_multiplier;

  localparam int WIDTH   = 8;
  localparam int FRAC    = 4;
  localparam int LATENCY = WIDTH + 1;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   cyc;

  simple_fixed_point_signed_multiplier_if #(.WIDTH(WIDTH)) bus ();

  simple_fixed_point_signed_multiplier #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Real-valued product a*b/2^(2*FRAC), truncated toward zero, clamped to range.
  function automatic logic [WIDTH:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int p;
    int q;
    int hi;
    int lo;
    hi = (1 << (WIDTH - 1)) - 1;
    lo = -(1 << (WIDTH - 1));
    p  = int'($signed(a)) * int'($signed(b));
    q  = p / (1 << FRAC);
    if (q > hi) return {1'b1, WIDTH'(hi)};
    if (q < lo) return {1'b1, WIDTH'(lo)};
    return {1'b0, WIDTH'(q)};
  endfunction

  task automatic wait_done(output int lat, output int busy_cycles, output bit timed_out);
    lat         = 0;
    busy_cycles = 0;
    timed_out   = 1'b0;
    while (bus.done !== 1'b1 && !timed_out) begin
      if (bus.busy === 1'b1) busy_cycles++;
      @(posedge clk);
      #1;
      lat++;
      if (lat > 40) timed_out = 1'b1;
    end
    if (timed_out) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles, required %0d", lat, LATENCY);
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output logic [WIDTH-1:0] res, output logic ovf,
                        output int lat, output int busy_cycles);
    bit to;
    bus.data_in_a = a;
    bus.data_in_b = b;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat, busy_cycles, to);
    res = bus.data_out;
    ovf = bus.overflow;
    if (!to) begin
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_with_done: busy=%b during done, required 0", bus.busy);
      end
    end
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.data_in_a = '0;
    bus.data_in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.data_out, bus.overflow} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b data_out=%h overflow=%b, required all 0",
               bus.busy, bus.done, bus.data_out, bus.overflow);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] res;
    logic             ovf;
    int               lat;
    int               bc;
    run_op(8'h18, 8'h20, res, ovf, lat, bc);
    checks++;
    if (lat != LATENCY) begin
      errors++;
      $display("FAIL basic_latency: %0d clocks, required %0d", lat, LATENCY);
    end
    checks++;
    if (bc != LATENCY) begin
      errors++;
      $display("FAIL basic_busy_cycles: %0d, required %0d", bc, LATENCY);
    end
    checks++;
    if ({ovf, res} !== {1'b0, 8'h30}) begin
      errors++;
      $display("FAIL basic_result: data_out=%h overflow=%b, required 30/0", res, ovf);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: done=%b one cycle later, required 0", bus.done);
    end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] va [10] = '{8'hE8, 8'hE8, 8'h18, 8'h70, 8'h80, 8'h80, 8'h90, 8'h01, 8'hFF, 8'h03};
    logic [WIDTH-1:0] vb [10] = '{8'h20, 8'hE0, 8'hE0, 8'h20, 8'hF0, 8'h10, 8'h20, 8'h08, 8'h08, 8'h08};
    logic [WIDTH-1:0] vr [10] = '{8'hD0, 8'h30, 8'hD0, 8'h7F, 8'h7F, 8'h80, 8'h80, 8'h00, 8'h00, 8'h01};
    logic             vo [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [WIDTH-1:0] res;
    logic             ovf;
    int               lat;
    int               bc;
    for (int i = 0; i < 10; i++) begin
      run_op(va[i], vb[i], res, ovf, lat, bc);
      checks++;
      if ({ovf, res} !== {vo[i], vr[i]}) begin
        errors++;
        $display("FAIL directed_%0d: %h x %h gave data_out=%h overflow=%b, required %h/%b",
                 i, va[i], vb[i], res, ovf, vr[i], vo[i]);
      end
      checks++;
      if (lat != LATENCY) begin
        errors++;
        $display("FAIL directed_latency_%0d: %0d clocks, required %0d", i, lat, LATENCY);
      end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] corners [5] = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01};
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   exp;
    logic [WIDTH-1:0] res;
    logic             ovf;
    int               lat;
    int               bc;
    for (int i = 0; i < 48; i++) begin
      a = (i < 8) ? corners[$urandom_range(4)] : WIDTH'($urandom);
      b = (i < 8) ? corners[$urandom_range(4)] : WIDTH'($urandom);
      exp = ref_mul(a, b);
      run_op(a, b, res, ovf, lat, bc);
      checks++;
      if ({ovf, res} !== exp) begin
        errors++;
        $display("FAIL random_%0d: %h x %h gave data_out=%h overflow=%b, required %h/%b",
                 i, a, b, res, ovf, exp[WIDTH-1:0], exp[WIDTH]);
      end
    end
  endtask

  task automatic test_ignored_start();
    int               dones;
    int               done_at;
    logic [WIDTH-1:0] res;
    logic             ovf;
    dones   = 0;
    done_at = -1;
    res     = '0;
    ovf     = 1'b0;
    bus.data_in_a = 8'h18;
    bus.data_in_b = 8'h20;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 20; c++) begin
      bus.start = (c == 3 || c == 5);
      if (c == 3 || c == 5) bus.data_in_b = 8'h70;
      if (c == 4) bus.data_in_a = 8'h7F;
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        dones++;
        if (done_at < 0) done_at = c;
        res = bus.data_out;
        ovf = bus.overflow;
      end
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL ignored_start_dones: %0d done pulses, required 1", dones);
    end
    checks++;
    if (done_at != LATENCY) begin
      errors++;
      $display("FAIL ignored_start_latency: done at %0d, required %0d", done_at, LATENCY);
    end
    checks++;
    if ({ovf, res} !== {1'b0, 8'h30}) begin
      errors++;
      $display("FAIL captured_operands: data_out=%h overflow=%b, required 30/0", res, ovf);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] oa [4];
    logic [WIDTH-1:0] ob [4];
    logic [WIDTH:0]   exp;
    int               lat;
    int               bc;
    int               prev_cyc;
    bit               to;
    for (int i = 0; i < 4; i++) begin
      oa[i] = WIDTH'($urandom);
      ob[i] = WIDTH'($urandom);
    end
    prev_cyc      = 0;
    bus.data_in_a = oa[0];
    bus.data_in_b = ob[0];
    bus.start     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      // Disturb the operands while the accepted operation is in flight.
      bus.data_in_a = WIDTH'($urandom);
      bus.data_in_b = WIDTH'($urandom);
      wait_done(lat, bc, to);
      if (to) break;
      exp = ref_mul(oa[i], ob[i]);
      checks++;
      if ({bus.overflow, bus.data_out} !== exp) begin
        errors++;
        $display("FAIL back_to_back_%0d: %h x %h gave data_out=%h overflow=%b, required %h/%b",
                 i, oa[i], ob[i], bus.data_out, bus.overflow, exp[WIDTH-1:0], exp[WIDTH]);
      end
      // The next accept lands on the edge after done, so pulses are LATENCY+1 apart.
      if (i > 0) begin
        checks++;
        if (cyc - prev_cyc != LATENCY + 1) begin
          errors++;
          $display("FAIL back_to_back_spacing_%0d: %0d clocks, required %0d",
                   i, cyc - prev_cyc, LATENCY + 1);
        end
      end
      prev_cyc = cyc;
      if (i < 3) begin
        bus.data_in_a = oa[i+1];
        bus.data_in_b = ob[i+1];
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op();
    logic [WIDTH-1:0] res;
    logic             ovf;
    int               lat;
    int               bc;
    int               dones;
    run_op(8'h70, 8'h20, res, ovf, lat, bc);
    checks++;
    if ({ovf, res} !== {1'b1, 8'h7F}) begin
      errors++;
      $display("FAIL pre_reset_result: data_out=%h overflow=%b, required 7f/1", res, ovf);
    end
    bus.data_in_a = 8'h18;
    bus.data_in_b = 8'h20;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.data_out, bus.overflow} !== '0) begin
      errors++;
      $display("FAIL reset_immediate: busy=%b done=%b data_out=%h overflow=%b, required all 0",
               bus.busy, bus.done, bus.data_out, bus.overflow);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.data_out, bus.overflow} !== '0) begin
      errors++;
      $display("FAIL reset_held: busy=%b done=%b data_out=%h overflow=%b, required all 0",
               bus.busy, bus.done, bus.data_out, bus.overflow);
    end
    reset_n = 1'b1;
    dones   = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL aborted_op_activity: %0d busy/done cycles after reset, required 0", dones);
    end
    run_op(8'h18, 8'h20, res, ovf, lat, bc);
    checks++;
    if ({ovf, res} !== {1'b0, 8'h30} || lat != LATENCY) begin
      errors++;
      $display("FAIL post_reset_op: data_out=%h overflow=%b latency=%0d, required 30/0/%0d",
               res, ovf, lat, LATENCY);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_directed();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
